// File: rtl/sat_pkg.sv
// Shared types and clamp limits for the saturation stage that follows the 16-bit adder.
package sat_pkg;

    localparam int SAT_W = 16;

    localparam logic [SAT_W-1:0] SAT_POS_MAX = 16'h7FFF;
    localparam logic [SAT_W-1:0] SAT_NEG_MIN = 16'h8000;
    localparam logic [SAT_W-1:0] SAT_U_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_POS  = 2'd1,
        SAT_NEG  = 2'd2,
        SAT_UMAX = 2'd3
    } sat_kind_e;

    function automatic logic sat_is_clamp(input sat_kind_e kind);
        return (kind != SAT_NONE);
    endfunction

endpackage

// File: rtl/sat_stage_if.sv
// Valid/ready bundle between the adder, the saturation stage and its consumer.
interface sat_stage_if #(parameter int WIDTH = sat_pkg::SAT_W);

    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] cout_in;
    logic             mode_s;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sat;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output sum_in, cout_in, mode_s, in_valid, out_ready,
        input  in_ready, out_data, out_sat, out_valid
    );

    modport slave (
        input  sum_in, cout_in, mode_s, in_valid, out_ready,
        output in_ready, out_data, out_sat, out_valid
    );

endinterface

// File: rtl/sat_detect.sv
// Combinational overflow classifier: picks the clamp kind and the clamped value
// from the top two adder carries.
module sat_detect
    import sat_pkg::*;
(
    input  logic [SAT_W-1:0] sum_in,
    input  logic             c1,
    input  logic             c0,
    input  logic             mode_s,
    output sat_kind_e        kind,
    output logic [SAT_W-1:0] value
);

    // signed overflow is carry-out != carry-into-MSB; unsigned is carry-out alone
    always_comb begin
        kind  = SAT_NONE;
        value = sum_in;
        case ({mode_s, c1, c0})
            3'b101: begin
                kind  = SAT_POS;
                value = SAT_POS_MAX;
            end
            3'b110: begin
                kind  = SAT_NEG;
                value = SAT_NEG_MIN;
            end
            3'b010, 3'b011: begin
                kind  = SAT_UMAX;
                value = SAT_U_MAX;
            end
            default: begin
                kind  = SAT_NONE;
                value = sum_in;
            end
        endcase
    end

endmodule

// File: rtl/sat_stage.sv
// Registered saturation stage with valid/ready handshake, sticky flag and optional
// event counter (enabled by defining SAT_CNT_EN; otherwise sat_cnt is tied to 0).
module sat_stage
    import sat_pkg::*;
#(
    parameter int WIDTH = SAT_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    sat_stage_if.slave       bus,
    input  logic             clr,
    output logic             sat_sticky,
    output logic [CNT_W-1:0] sat_cnt
);

    sat_kind_e        kind_s;
    logic [SAT_W-1:0] value_s;
    logic             clamp_s;
    logic             accept_s;
    logic             clamp_acc_s;
    logic [WIDTH-1:0] data_r;
    logic             sat_r;
    logic             valid_r;
    logic             sticky_r;

    sat_detect u_detect (
        .sum_in (bus.sum_in),
        .c1     (bus.cout_in[WIDTH-1]),
        .c0     (bus.cout_in[WIDTH-2]),
        .mode_s (bus.mode_s),
        .kind   (kind_s),
        .value  (value_s)
    );

    assign clamp_s       = sat_is_clamp(kind_s);
    assign bus.in_ready  = !valid_r | bus.out_ready;
    assign accept_s      = bus.in_valid & bus.in_ready;
    assign clamp_acc_s   = accept_s & clamp_s;
    assign bus.out_data  = data_r;
    assign bus.out_sat   = sat_r;
    assign bus.out_valid = valid_r;
    assign sat_sticky    = sticky_r;

    // output register: reload on accept (also during a consume), drop valid on a bare consume
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r  <= '0;
            sat_r   <= 1'b0;
            valid_r <= 1'b0;
        end else if (accept_s) begin
            data_r  <= value_s;
            sat_r   <= clamp_s;
            valid_r <= 1'b1;
        end else if (bus.out_ready) begin
            valid_r <= 1'b0;
        end
    end

    // sticky flag; a same-cycle clamp beats clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_r <= 1'b0;
        end else if (clamp_acc_s) begin
            sticky_r <= 1'b1;
        end else if (clr) begin
            sticky_r <= 1'b0;
        end
    end

`ifdef SAT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    logic [CNT_W-1:0] cnt_r;

    // saturating event counter; clr with a same-cycle clamp restarts at one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clamp_acc_s) begin
            if (clr) begin
                cnt_r <= CNT_ONE;
            end else if (&cnt_r) begin
                cnt_r <= cnt_r;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else if (clr) begin
            cnt_r <= '0;
        end
    end

    assign sat_cnt = cnt_r;
`else
    assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_sat_stage.sv
// Self-checking bench for sat_stage: directed table, backpressure/counter/reset
// sequences and randomized operands against an arithmetic reference model.
module tb_sat_stage;

    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SAT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             clr;
    logic             sat_sticky;
    logic [CNT_W-1:0] sat_cnt;

    sat_stage_if #(.WIDTH(16)) bus ();

    sat_stage #(.WIDTH(16), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr        (clr),
        .sat_sticky (sat_sticky),
        .sat_cnt    (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference state
    bit          m_valid;
    logic [15:0] m_data;
    bit          m_sat;
    bit          m_sticky;
    int          m_cnt;

    typedef struct {
        logic [15:0] sum;
        logic        c1;
        logic        c0;
        logic        mode;
        logic [15:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_data = 16'h0000; m_sat = 1'b0; m_sticky = 1'b0; m_cnt = 0;
    endtask

    task automatic drive(input logic vld, input logic [15:0] sum, input logic [15:0] cout,
                         input logic mode, input logic ordy, input logic c);
        bus.in_valid = vld; bus.sum_in = sum; bus.cout_in = cout;
        bus.mode_s = mode; bus.out_ready = ordy; clr = c;
    endtask

    // one clock: check in_ready, advance the model on the edge, then check outputs
    task automatic step(input logic [15:0] ed, input logic es);
        bit acc;
        #1;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (!m_valid || bus.out_ready)});
        @(posedge clk);
        acc = bus.in_valid && (!m_valid || bus.out_ready);
        if (acc) begin
            m_valid = 1'b1; m_data = ed; m_sat = es;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
        if (acc && es) begin
            m_sticky = 1'b1;
            m_cnt = clr ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
        end else if (clr) begin
            m_sticky = 1'b0; m_cnt = 0;
        end
        #1;
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        chk("out_data", {16'd0, bus.out_data}, {16'd0, m_data});
        chk("out_sat", {31'd0, bus.out_sat}, {31'd0, m_sat});
        chk("sat_sticky", {31'd0, sat_sticky}, {31'd0, m_sticky});
        chk("sat_cnt", {24'd0, sat_cnt}, CNT_ON ? m_cnt : 0);
        @(negedge clk);
    endtask

    // builds the adder's sum and carries from real operands and the ideal saturated result
    task automatic ref_op(input logic [15:0] a, input logic [15:0] b, input logic mode,
                          output logic [15:0] sum, output logic [15:0] cout,
                          output logic [15:0] ed, output logic es);
        int ua, ub, u, sa, sb, s, lo;
        logic [13:0] junk;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        u = ua + ub; s = sa + sb;
        lo = (ua & 32'h7FFF) + (ub & 32'h7FFF);
        junk = 14'($urandom);
        sum = u[15:0];
        cout = {(u > 32'hFFFF), (lo > 32'h7FFF), junk};
        es = 1'b0; ed = sum;
        if (mode) begin
            if (s > 32767) begin ed = 16'h7FFF; es = 1'b1; end
            else if (s < -32768) begin ed = 16'h8000; es = 1'b1; end
        end else if (u > 65535) begin
            ed = 16'hFFFF; es = 1'b1;
        end
    endtask

    logic [15:0] a, b, sum, cout, ed;
    logic        es, mode;

    initial begin
        tbl[0] = '{16'h0007, 1'b0, 1'b0, 1'b1, 16'h0007, 1'b0};
        tbl[1] = '{16'h8000, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1};
        tbl[2] = '{16'h7FFF, 1'b1, 1'b0, 1'b1, 16'h8000, 1'b1};
        tbl[3] = '{16'h0001, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b1};
        tbl[4] = '{16'h0001, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0};
        tbl[5] = '{16'h1234, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0};
        tbl[6] = '{16'hFFFE, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0};

        rst = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        model_reset();
        #12;
        chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset out_data", {16'd0, bus.out_data}, 32'd0);
        chk("reset sticky", {31'd0, sat_sticky}, 32'd0);
        chk("reset cnt", {24'd0, sat_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // directed vectors; lower carry bits carry junk that must be ignored
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, tbl[i].sum, {tbl[i].c1, tbl[i].c0, 14'h2A5A}, tbl[i].mode, 1'b1, 1'b0);
            step(tbl[i].exp_data, tbl[i].exp_sat);
            chk("tbl data", {16'd0, bus.out_data}, {16'd0, tbl[i].exp_data});
            chk("tbl sat", {31'd0, bus.out_sat}, {31'd0, tbl[i].exp_sat});
            if (i == 0) chk("tbl sticky0", {31'd0, sat_sticky}, 32'd0);
        end

        // backpressure: hold word A for 3 cycles while B waits, then B loads with no bubble
        drive(1'b1, 16'h0A0A, 16'h0000, 1'b1, 1'b1, 1'b0);
        step(16'h0A0A, 1'b0);
        drive(1'b1, 16'h0B0B, 16'h0000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(16'h0B0B, 1'b0);
            chk("bp hold data", {16'd0, bus.out_data}, 32'h0A0A);
            chk("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        step(16'h0B0B, 1'b0);
        chk("bp reload data", {16'd0, bus.out_data}, 32'h0B0B);
        chk("bp no bubble", {31'd0, bus.out_valid}, 32'd1);

        // counter saturation, then clr racing a clamp, then a plain clr
        drive(1'b1, 16'h8000, 16'h4000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) step(16'h7FFF, 1'b1);
        chk("cnt saturate", {24'd0, sat_cnt}, CNT_ON ? CNT_MAX : 0);
        clr = 1'b1;
        step(16'h7FFF, 1'b1);
        chk("clr+clamp cnt", {24'd0, sat_cnt}, CNT_ON ? 1 : 0);
        chk("clr+clamp sticky", {31'd0, sat_sticky}, 32'd1);
        bus.in_valid = 1'b0;
        step(16'h0000, 1'b0);
        chk("clr sticky", {31'd0, sat_sticky}, 32'd0);
        clr = 1'b0;

        // randomized operands, handshakes and clears
        for (int i = 0; i < 600; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = {a[15], 15'h7FF0} | 16'($urandom_range(0, 15));
            mode = 1'($urandom);
            ref_op(a, b, mode, sum, cout, ed, es);
            drive(($urandom_range(0, 3) != 0), sum, cout, mode,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
            step(ed, es);
        end

        // async reset with a held output: cleared immediately, no replay afterwards
        drive(1'b1, 16'h1111, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(16'h1111, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async rst valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async rst data", {16'd0, bus.out_data}, 32'd0);
        chk("async rst sticky", {31'd0, sat_sticky}, 32'd0);
        model_reset();
        drive(1'b0, 16'h1111, 16'h0000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(16'h0000, 1'b0);
        chk("no replay", {31'd0, bus.out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
